// File: rtl/pll_lock_sequencer.sv
// PLL power-up / recovery sequencer: reset pulse, lock wait with timeout and
// bounded retries, lock stability qualification, and lock-loss re-sequencing.
module pll_lock_sequencer #(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart_req,
  output logic       pll_rst,
  output logic       sys_ready,
  output logic       fault,
  output logic [2:0] state,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int MAX_A   = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  // timer only ever reaches MAX_CYC-1, so clog2 bits suffice
  localparam int TW      = $clog2(MAX_CYC);

  localparam logic [TW-1:0] HOLD_LAST    = TW'(RST_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_WAIT   = 3'd1,
    S_STAB   = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4
  } state_e;

  state_e        st;
  logic [TW-1:0] timer;
  logic          sync1, locked_s;
  logic [3:0]    retry_nxt;

  assign state     = st;
  assign retry_nxt = retry_cnt + 4'd1;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= S_HOLD;
      timer         <= '0;
      pll_rst       <= 1'b1;
      sys_ready     <= 1'b0;
      fault         <= 1'b0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
    end else if (restart_req) begin
      // restart outranks everything, including a same-cycle lock loss in RUN
      st        <= S_HOLD;
      timer     <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_ready <= 1'b0;
      fault     <= 1'b0;
    end else begin
      case (st)
        S_HOLD: begin
          if (timer == HOLD_LAST) begin
            st      <= S_WAIT;
            timer   <= '0;
            pll_rst <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_WAIT: begin
          if (locked_s) begin
            st    <= S_STAB;
            timer <= '0;
          end else if (timer == TIMEOUT_LAST) begin
            timer     <= '0;
            retry_cnt <= retry_nxt;
            pll_rst   <= 1'b1;
            if (retry_nxt == RETRY_LIMIT) begin
              st    <= S_FAULT;
              fault <= 1'b1;
            end else begin
              st <= S_HOLD;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_STAB: begin
          if (!locked_s) begin
            st    <= S_WAIT;
            timer <= '0;
          end else if (timer == STABLE_LAST) begin
            st        <= S_RUN;
            timer     <= '0;
            sys_ready <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            st        <= S_HOLD;
            timer     <= '0;
            pll_rst   <= 1'b1;
            sys_ready <= 1'b0;
            retry_cnt <= '0;
            if (lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
          end
        end
        S_FAULT: begin
          pll_rst   <= 1'b1;
          fault     <= 1'b1;
          sys_ready <= 1'b0;
        end
        default: begin
          st        <= S_HOLD;
          timer     <= '0;
          pll_rst   <= 1'b1;
          sys_ready <= 1'b0;
          fault     <= 1'b0;
        end
      endcase
    end
  end

endmodule
